// File: rtl/foc_timing_pkg.sv
// Shared timing types and defaults for the FOC carrier timebase.
package foc_timing_pkg;

  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned DIV_W_DEF       = 4;
  localparam int unsigned HOLD_CYCLES_DEF = 1024;
  // 20 kHz carrier at 100 MHz: 100e6 / (2 * 20e3) = 2500 half-period counts
  localparam int unsigned PERIOD_20K      = 2500;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    IDLE  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/reset_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, deasserts on the 2nd clk edge.
module reset_sync (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n
);

  logic r_meta;
  logic r_sync;

  // Shift a constant 1 through two flops once rst_n is released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= 1'b1;
      r_sync <= r_meta;
    end
  end

  assign rst_sync_n = r_sync;

endmodule

// File: rtl/foc_timebase.sv
// Centre-aligned PWM carrier and phase strobes with reset synchronisation and settle hold.
module foc_timebase
  import foc_timing_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int unsigned DIV_W       = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] trig_point,
  input  logic [DIV_W-1:0] loop_div,
  output logic             rst_sync_n,
  output logic             ready,
  output logic [CNT_W-1:0] cnt,
  output logic             dir_down,
  output logic             zero_stb,
  output logic             peak_stb,
  output logic             adc_trig,
  output logic             loop_tick
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  logic             w_rst_sync_n;
  state_e           r_state;
  state_e           w_state_nxt;
  logic [HOLD_W-1:0] r_hold;
  logic             r_ready;
  logic [CNT_W-1:0] r_cnt, r_period_q, r_trig_q;
  logic [DIV_W-1:0] r_div_q, r_loop;
  logic             r_dir, r_zero, r_peak, r_adc, r_tick;

  logic             w_running_nxt;
  logic             w_load;
  logic [CNT_W-1:0] w_period_nxt, w_trig_nxt, w_cnt_nxt;
  logic [DIV_W-1:0] w_div_nxt, w_loop_nxt;
  logic             w_dir_nxt, w_zero_nxt, w_peak_nxt, w_adc_nxt, w_tick_nxt;

  reset_sync u_reset_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_sync_n (w_rst_sync_n)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= HOLD;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; a stop request only takes effect on a cnt==0 cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HOLD:    if (w_rst_sync_n && (r_hold == HOLD_W'(HOLD_CYCLES - 1))) w_state_nxt = IDLE;
      IDLE:    if (en) w_state_nxt = RUN;
      RUN:     if (!en) w_state_nxt = (r_cnt == '0) ? IDLE : DRAIN;
      DRAIN:   if (en) w_state_nxt = RUN;
               else if (r_cnt == '0) w_state_nxt = IDLE;
      default: w_state_nxt = HOLD;
    endcase
  end

  // Next carrier value, shadow registers and strobes for the cycle after this edge
  always_comb begin
    w_running_nxt = (w_state_nxt == RUN) || (w_state_nxt == DRAIN);
    w_load        = ((r_state == IDLE) && en) || ((r_state == RUN) && (r_cnt == '0));

    w_period_nxt = r_period_q;
    w_trig_nxt   = r_trig_q;
    w_div_nxt    = r_div_q;
    if (w_load) begin
      w_period_nxt = (period == '0) ? CNT_W'(1) : period;
      w_trig_nxt   = trig_point;
      w_div_nxt    = (loop_div == '0) ? DIV_W'(1) : loop_div;
    end

    w_cnt_nxt  = '0;
    w_dir_nxt  = 1'b0;
    w_loop_nxt = '0;
    if (w_running_nxt && (r_state != IDLE)) begin
      w_loop_nxt = r_loop;
      if (r_cnt == '0) begin
        w_cnt_nxt  = CNT_W'(1);
        w_loop_nxt = (r_loop >= (w_div_nxt - DIV_W'(1))) ? '0 : (r_loop + DIV_W'(1));
      end else if (!r_dir && (r_cnt < r_period_q)) begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end else begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        w_dir_nxt = (w_cnt_nxt != '0);
      end
    end

    w_zero_nxt = w_running_nxt && (w_cnt_nxt == '0);
    w_peak_nxt = w_running_nxt && (w_cnt_nxt == w_period_nxt);
    w_adc_nxt  = w_running_nxt && (w_cnt_nxt == w_trig_nxt) &&
                 (w_dir_nxt || (w_cnt_nxt == w_period_nxt) || (w_cnt_nxt == '0));
    w_tick_nxt = w_zero_nxt && (w_loop_nxt == '0);
  end

  // Registered datapath and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold     <= '0;
      r_ready    <= 1'b0;
      r_cnt      <= '0;
      r_period_q <= CNT_W'(1);
      r_trig_q   <= '0;
      r_div_q    <= DIV_W'(1);
      r_loop     <= '0;
      r_dir      <= 1'b0;
      r_zero     <= 1'b0;
      r_peak     <= 1'b0;
      r_adc      <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      if ((r_state == HOLD) && w_rst_sync_n) r_hold <= r_hold + HOLD_W'(1);
      r_ready    <= (w_state_nxt != HOLD);
      r_cnt      <= w_cnt_nxt;
      r_period_q <= w_period_nxt;
      r_trig_q   <= w_trig_nxt;
      r_div_q    <= w_div_nxt;
      r_loop     <= w_loop_nxt;
      r_dir      <= w_dir_nxt;
      r_zero     <= w_zero_nxt;
      r_peak     <= w_peak_nxt;
      r_adc      <= w_adc_nxt;
      r_tick     <= w_tick_nxt;
    end
  end

  assign rst_sync_n = w_rst_sync_n;
  assign ready      = r_ready;
  assign cnt        = r_cnt;
  assign dir_down   = r_dir;
  assign zero_stb   = r_zero;
  assign peak_stb   = r_peak;
  assign adc_trig   = r_adc;
  assign loop_tick  = r_tick;

endmodule

// File: tb/tb_foc_timebase.sv
// Directed self-checking bench for foc_timebase (HOLD_CYCLES = 16).
module tb_foc_timebase;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] period;
  logic [15:0] trig_point;
  logic [3:0]  loop_div;
  logic        rst_sync_n;
  logic        ready;
  logic [15:0] cnt;
  logic        dir_down;
  logic        zero_stb;
  logic        peak_stb;
  logic        adc_trig;
  logic        loop_tick;

  int total = 0;
  int bad   = 0;

  logic [20:0] obs;
  assign obs = {cnt, dir_down, zero_stb, peak_stb, adc_trig, loop_tick};

  // P=4 carrier: count and {dir,zero,peak} flags; adc/tick bits added per phase
  logic [15:0] c4  [8]  = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd3, 16'd2, 16'd1};
  logic [4:0]  fb4 [8]  = '{5'b01000, 5'b00000, 5'b00000, 5'b00000,
                            5'b00100, 5'b10000, 5'b10000, 5'b10000};
  // P=6 carrier with trig=2, div=1: {dir,zero,peak,adc,tick}
  logic [15:0] c6  [12] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5,
                            16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
  logic [4:0]  f6  [12] = '{5'b01001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
                            5'b00100, 5'b10000, 5'b10000, 5'b10000, 5'b10010, 5'b10000};

  foc_timebase #(
    .CNT_W       (16),
    .HOLD_CYCLES (16),
    .DIV_W       (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .period     (period),
    .trig_point (trig_point),
    .loop_div   (loop_div),
    .rst_sync_n (rst_sync_n),
    .ready      (ready),
    .cnt        (cnt),
    .dir_down   (dir_down),
    .zero_stb   (zero_stb),
    .peak_stb   (peak_stb),
    .adc_trig   (adc_trig),
    .loop_tick  (loop_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Compares {cnt,dir,zero,peak,adc,tick} as one packed word
  task automatic chk_cyc(input string tag, input int i, input logic [15:0] ecnt, input logic [4:0] ef);
    chk($sformatf("%s[%0d]", tag, i), 32'(obs), 32'({ecnt, ef}));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] ef;
    rst_n      = 1'b0;
    en         = 1'b0;
    period     = 16'd4;
    trig_point = 16'd2;
    loop_div   = 4'd1;

    // Reset state
    #12;
    chk("rst_sync_n_in_reset", 32'(rst_sync_n), 32'd0);
    chk("ready_in_reset", 32'(ready), 32'd0);
    chk_cyc("outs_in_reset", 0, 16'd0, 5'b00000);

    // Release reset: synchroniser then settle hold
    rst_n = 1'b1;
    step();
    chk("rst_sync_n_edge1", 32'(rst_sync_n), 32'd0);
    step();
    chk("rst_sync_n_edge2", 32'(rst_sync_n), 32'd1);
    chk("ready_edge2", 32'(ready), 32'd0);
    repeat (15) step();
    chk("ready_edge17", 32'(ready), 32'd0);
    step();
    chk("ready_edge18", 32'(ready), 32'd1);
    chk_cyc("idle_after_hold", 0, 16'd0, 5'b00000);

    // P=4, trig=2, div=1; widen period to 6 on cnt=2 of the second up-ramp
    en = 1'b1;
    for (int i = 0; i <= 28; i++) begin
      step();
      if (i < 16) begin
        ef = fb4[i % 8] | ((i % 8 == 6) ? 5'b00010 : 5'b00000) | ((i % 8 == 0) ? 5'b00001 : 5'b00000);
        chk_cyc("p4_trig2", i, c4[i % 8], ef);
      end else begin
        chk_cyc("p6_trig2", i, c6[(i - 16) % 12], f6[(i - 16) % 12]);
      end
      if (i == 10) period = 16'd6;
    end

    // Stop on a zero cycle, then stay idle
    en         = 1'b0;
    period     = 16'd4;
    trig_point = 16'd7;
    loop_div   = 4'd3;
    step();
    chk_cyc("stop_at_zero_idle", 0, 16'd0, 5'b00000);
    step();
    chk_cyc("idle_hold", 1, 16'd0, 5'b00000);
    chk("ready_sticky", 32'(ready), 32'd1);

    // trig beyond peak never fires; loop_tick on zeros 1, 4, 7
    en = 1'b1;
    for (int i = 0; i <= 48; i++) begin
      step();
      ef = fb4[i % 8] | (((i % 8 == 0) && ((i / 8) % 3 == 0)) ? 5'b00001 : 5'b00000);
      chk_cyc("trig7_div3", i, c4[i % 8], ef);
    end

    en         = 1'b0;
    trig_point = 16'd4;
    loop_div   = 4'd0;
    step();
    chk_cyc("idle_after_div3", 0, 16'd0, 5'b00000);

    // trig at peak, div=0 ticks every zero; en dropped at cnt=3 drains to zero
    en = 1'b1;
    for (int i = 0; i <= 24; i++) begin
      step();
      ef = fb4[i % 8] | ((i % 8 == 4) ? 5'b00010 : 5'b00000) | ((i % 8 == 0) ? 5'b00001 : 5'b00000);
      chk_cyc("trig4_div0_drain", i, c4[i % 8], ef);
      if (i == 19) en = 1'b0;
    end
    step();
    chk_cyc("idle_after_drain", 0, 16'd0, 5'b00000);
    step();
    chk_cyc("idle_after_drain", 1, 16'd0, 5'b00000);

    // en for one edge only: a single zero cycle then idle
    en = 1'b1;
    step();
    chk_cyc("single_run", 0, 16'd0, 5'b01001);
    en = 1'b0;
    step();
    chk_cyc("single_run_idle", 1, 16'd0, 5'b00000);

    // period=0 clamps to 1; trig=1 coincides with the peak
    period     = 16'd0;
    trig_point = 16'd1;
    loop_div   = 4'd1;
    en         = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i % 2 == 0) chk_cyc("period0_clamp", i, 16'd0, 5'b01001);
      else            chk_cyc("period0_clamp", i, 16'd1, 5'b00110);
    end

    // Asynchronous reset mid-ramp clears everything before the next edge
    rst_n = 1'b0;
    #1;
    chk_cyc("async_reset_outs", 0, 16'd0, 5'b00000);
    chk("async_reset_ready", 32'(ready), 32'd0);
    chk("async_reset_sync", 32'(rst_sync_n), 32'd0);
    step();
    chk_cyc("reset_held_outs", 1, 16'd0, 5'b00000);
    chk("reset_held_ready", 32'(ready), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
